// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game sequencer: game FSM, BCD score, balls left, rgb layer mux
module pong_game_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned TIMER_FRAMES = 120,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  btn_i,
    input  logic        frame_tick_i,
    input  logic        hit_i,
    input  logic        miss_i,
    input  logic        video_on_i,
    input  logic        graph_on_i,
    input  logic [11:0] graph_rgb_i,
    input  logic [3:0]  text_on_i,
    input  logic [11:0] text_rgb_i,
    output logic        gra_still_o,
    output logic [3:0]  dig1_o,
    output logic [3:0]  dig0_o,
    output logic [1:0]  ball_o,
    output logic [11:0] rgb_o
);

    typedef enum logic [1:0] {
        S_NEWGAME = 2'd0,
        S_PLAY    = 2'd1,
        S_NEWBALL = 2'd2,
        S_OVER    = 2'd3
    } state_e;

    localparam logic [1:0] BALLS_L = 2'(BALLS);
    localparam logic [6:0] TIMER_L = 7'(TIMER_FRAMES);

    state_e      state_q, state_d;
    logic [6:0]  timer_q, timer_d;
    logic [3:0]  dig1_q, dig1_d, dig0_q, dig0_d;
    logic [1:0]  ball_q, ball_d;
    logic [11:0] rgb_q, rgb_d;
    logic        timer_up, press, timer_load;

    assign timer_up = (timer_q == 7'd0);
    assign press    = (btn_i != 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_NEWGAME;
            timer_q <= 7'd0;
            dig1_q  <= 4'd0;
            dig0_q  <= 4'd0;
            ball_q  <= BALLS_L;
            rgb_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dig1_q  <= dig1_d;
            dig0_q  <= dig0_d;
            ball_q  <= ball_d;
            rgb_q   <= rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NEWGAME: if (press) state_d = S_PLAY;
            S_PLAY:    if (miss_i) state_d = (ball_q == 2'd0) ? S_OVER : S_NEWBALL;
            S_NEWBALL: if (timer_up && press) state_d = S_PLAY;
            S_OVER:    if (timer_up) state_d = S_NEWGAME;
            default:   state_d = S_NEWGAME;
        endcase
    end

    // Score, balls and timer; the score survives OVER->NEWGAME until the next press.
    always_comb begin
        dig1_d     = dig1_q;
        dig0_d     = dig0_q;
        ball_d     = ball_q;
        timer_load = 1'b0;
        unique case (state_q)
            S_NEWGAME: begin
                ball_d = BALLS_L;
                if (press) begin
                    dig1_d = 4'd0;
                    dig0_d = 4'd0;
                    ball_d = BALLS_L - 2'd1;
                end
            end
            S_PLAY: begin
                if (hit_i) begin
                    if (dig0_q == 4'd9) begin
                        dig0_d = 4'd0;
                        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
                    end else begin
                        dig0_d = dig0_q + 4'd1;
                    end
                end
                if (miss_i) begin
                    timer_load = 1'b1;
                    if (ball_q != 2'd0) ball_d = ball_q - 2'd1;
                end
            end
            S_OVER: if (timer_up) ball_d = BALLS_L;
            default: ;
        endcase

        if (timer_load)
            timer_d = TIMER_L;
        else if (frame_tick_i && !timer_up)
            timer_d = timer_q - 7'd1;
        else
            timer_d = timer_q;
    end

    always_comb begin
        gra_still_o = (state_q != S_PLAY);
        if (!video_on_i)
            rgb_d = 12'h000;
        else if (text_on_i[3])
            rgb_d = text_rgb_i;
        else if (text_on_i[1] && state_q == S_NEWGAME)
            rgb_d = text_rgb_i;
        else if (text_on_i[0] && state_q == S_OVER)
            rgb_d = text_rgb_i;
        else if (graph_on_i)
            rgb_d = graph_rgb_i;
        else if (text_on_i[2])
            rgb_d = text_rgb_i;
        else
            rgb_d = BG_COLOR;
    end

    assign dig1_o = dig1_q;
    assign dig0_o = dig0_q;
    assign ball_o = ball_q;
    assign rgb_o  = rgb_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

    localparam int BALLS = 3;
    localparam int TF    = 120;
    localparam int BG    = 12'h000;

    logic        clk, rst_n;
    logic [1:0]  btn;
    logic        frame_tick, hit, miss, video_on, graph_on;
    logic [11:0] graph_rgb, text_rgb;
    logic [3:0]  text_on;
    logic        gra_still;
    logic [3:0]  dig1, dig0;
    logic [1:0]  ball;
    logic [11:0] rgb;

    pong_game_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .frame_tick_i(frame_tick),
        .hit_i(hit), .miss_i(miss), .video_on_i(video_on), .graph_on_i(graph_on),
        .graph_rgb_i(graph_rgb), .text_on_i(text_on), .text_rgb_i(text_rgb),
        .gra_still_o(gra_still), .dig1_o(dig1), .dig0_o(dig0), .ball_o(ball), .rgb_o(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef enum {M_NEW, M_PLAY, M_NBALL, M_OVER} mode_t;
    mode_t m_mode;
    int    m_score, m_balls, m_tmr, m_rgb;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_NEW; m_score = 0; m_balls = BALLS; m_tmr = 0; m_rgb = 0;
    endtask

    function automatic int rgb_ref(mode_t md, logic vid, logic gon, int grgb,
                                   logic [3:0] ton, int trgb);
        if (!vid) return 0;
        if (ton[3]) return trgb;
        if (ton[1] && md == M_NEW) return trgb;
        if (ton[0] && md == M_OVER) return trgb;
        if (gon) return grgb;
        if (ton[2]) return trgb;
        return BG;
    endfunction

    // Reference model: advances the game rules by one clock using the applied inputs.
    task automatic model_step();
        bit pressed, load;
        pressed = (btn != 0);
        load = 0;
        m_rgb = rgb_ref(m_mode, video_on, graph_on, graph_rgb, text_on, text_rgb);
        case (m_mode)
            M_NEW: begin
                if (pressed) begin m_score = 0; m_balls = BALLS - 1; m_mode = M_PLAY; end
                else m_balls = BALLS;
            end
            M_PLAY: begin
                if (hit) m_score = (m_score + 1) % 100;
                if (miss) begin
                    load = 1;
                    if (m_balls == 0) m_mode = M_OVER;
                    else begin m_balls--; m_mode = M_NBALL; end
                end
            end
            M_NBALL: if (m_tmr == 0 && pressed) m_mode = M_PLAY;
            M_OVER:  if (m_tmr == 0) begin m_mode = M_NEW; m_balls = BALLS; end
        endcase
        if (load) m_tmr = TF;
        else if (frame_tick && m_tmr > 0) m_tmr--;
    endtask

    task automatic step(input logic [1:0] b, input logic ft, input logic h, input logic m,
                        input logic vid, input logic gon, input logic [3:0] ton);
        btn = b; frame_tick = ft; hit = h; miss = m;
        video_on = vid; graph_on = gon; text_on = ton;
        @(posedge clk);
        model_step();
        #1;
        chk("gra_still", int'(gra_still), int'(m_mode != M_PLAY));
        chk("dig1", int'(dig1), m_score / 10);
        chk("dig0", int'(dig0), m_score % 10);
        chk("ball", int'(ball), m_balls);
        chk("rgb", int'(rgb), m_rgb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    endtask

    // Hold btn through the whole serve timer, then one more edge to enter PLAY.
    task automatic serve_wait();
        for (int i = 0; i < TF; i++) begin
            step(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
            chk("nb_still", int'(gra_still), 1);
        end
        step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        chk("nb_to_play", int'(gra_still), 0);
        idle(1);
    endtask

    typedef struct {
        bit          in_play;
        logic        vid;
        logic        gon;
        logic [3:0]  ton;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 1'b0, 1'b1, 4'b1000, 12'h000};
        tbl[1] = '{0, 1'b1, 1'b1, 4'b1000, 12'hFFF};
        tbl[2] = '{0, 1'b1, 1'b1, 4'b0100, 12'h0F0};
        tbl[3] = '{0, 1'b1, 1'b0, 4'b0010, 12'hFFF};
        tbl[4] = '{0, 1'b1, 1'b1, 4'b0001, 12'h0F0};
        tbl[5] = '{0, 1'b1, 1'b0, 4'b0000, 12'h000};
        tbl[6] = '{1, 1'b1, 1'b0, 4'b0010, 12'h000};
        tbl[7] = '{1, 1'b1, 1'b0, 4'b1000, 12'hFFF};
        tbl[8] = '{1, 1'b1, 1'b0, 4'b0100, 12'hFFF};
        tbl[9] = '{1, 1'b1, 1'b0, 4'b0001, 12'h000};

        rst_n = 1'b0; btn = 0; frame_tick = 0; hit = 0; miss = 0;
        video_on = 0; graph_on = 0; text_on = 0;
        graph_rgb = 12'h0F0; text_rgb = 12'hFFF;
        model_reset();
        #22 rst_n = 1'b1;
        chk("rst_still", int'(gra_still), 1);
        chk("rst_ball", int'(ball), 3);
        chk("rst_dig", int'({dig1, dig0}), 0);
        chk("rst_rgb", int'(rgb), 0);
        idle(3);
        chk("idle_ball", int'(ball), 3);

        for (int i = 0; i < 10; i++) if (!tbl[i].in_play) begin
            step(2'b00, 1'b0, 1'b0, 1'b0, tbl[i].vid, tbl[i].gon, tbl[i].ton);
            chk($sformatf("tbl%0d_rgb", i), int'(rgb), int'(tbl[i].exp_rgb));
        end

        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 10; i++) if (tbl[i].in_play) begin
            step(2'b00, 1'b0, 1'b0, 1'b0, tbl[i].vid, tbl[i].gon, tbl[i].ton);
            chk($sformatf("tbl%0d_rgb", i), int'(rgb), int'(tbl[i].exp_rgb));
        end

        for (int i = 0; i < 12; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        chk("score12_still", int'(gra_still), 0);
        chk("score12_ball", int'(ball), 2);
        chk("score12_dig", int'({dig1, dig0}), 8'h12);
        for (int i = 0; i < 88; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        chk("wrap99_dig", int'({dig1, dig0}), 8'h00);

        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        chk("miss_ball", int'(ball), 1);
        chk("miss_still", int'(gra_still), 1);
        serve_wait();

        for (int i = 0; i < 7; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        chk("pre_rst_dig", int'({dig1, dig0}), 8'h07);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_still", int'(gra_still), 1);
        chk("async_ball", int'(ball), 3);
        chk("async_dig", int'({dig1, dig0}), 0);
        chk("async_rgb", int'(rgb), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        serve_wait();
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        serve_wait();
        chk("last_ball", int'(ball), 0);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        chk("over_dig", int'({dig1, dig0}), 8'h04);
        chk("over_still", int'(gra_still), 1);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
        chk("over_text", int'(rgb), 12'hFFF);
        for (int i = 0; i < TF; i++) step(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        chk("over_hold_dig", int'({dig1, dig0}), 8'h04);
        idle(1);
        chk("newgame_ball", int'(ball), 3);
        chk("newgame_dig", int'({dig1, dig0}), 8'h04);
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        chk("restart_dig", int'({dig1, dig0}), 8'h00);
        chk("restart_ball", int'(ball), 2);

        for (int i = 0; i < 6000; i++) begin
            graph_rgb = 12'($urandom);
            text_rgb  = 12'($urandom);
            step(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
